// File: rtl/dct_serial_rx_framer.sv
// dct_serial_rx_framer
//   Serial front end for the DCT cores. Deserialises an iSDAT/iSVAL bitstream
//   (LANES bits per beat, MSB-first) into DATA_W-bit coefficients, frames them
//   into blocks of 4/8/16/32 points chosen by iSize at block start, and buffers
//   them with SOF/EOF tags in a first-word-fall-through FIFO.
//
//   Optional feature macro: DCT_RX_TIMEOUT_EN
//     defined   - an idle gap of TIMEOUT_CYC cycles inside a block aborts it
//                 (partial word dropped, oSizeErr pulses, FSM back to IDLE)
//     undefined - gaps of any length are legal
//
// Ports
//   iClk, iRst_n      clock (rising edge), asynchronous active-low reset
//   iSize[2:0]        block size code 0..3 -> 4/8/16/32 points, 4..7 illegal
//   iSVAL, iSDAT      serial beat valid / LANES data bits
//   oData/oSof/oEof   FIFO head word and its block tags (zero when empty)
//   oValid, iReady    head valid (FIFO non-empty) / consumer accept
//   oOverflow         sticky: a word was dropped on a full FIFO
//   oSizeErr          1-cycle pulse: illegal size at block start (or timeout)
//   oBusy             block in progress
//
// FSM states
//   state | meaning
//   IDLE  | waiting for the first beat of a block; iSize sampled here
//   SHIFT | block in progress; beats shifted in until the last word is pushed
module dct_serial_rx_framer #(
  parameter int DATA_W      = 16,
  parameter int LANES       = 1,
  parameter int FIFO_DEPTH  = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [2:0]        iSize,
  input  logic              iSVAL,
  input  logic [LANES-1:0]  iSDAT,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oSof,
  output logic              oEof,
  output logic              oOverflow,
  output logic              oSizeErr,
  output logic              oBusy
);

  localparam int BEATS = DATA_W / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BW-1:0]     beat_cnt;
  logic [4:0]        word_idx, last_idx;
  logic [1:0]        size_q, size_cur;
  logic              size_ok, accept, word_done, last_word, abort;
  logic              size_err, size_err_nxt, overflow;

  // one-register push stage between the shifter and the FIFO
  logic              push_vld, push_sof, push_eof;
  logic [DATA_W-1:0] push_data;

  assign size_ok   = (iSize <= 3'd3);
  assign size_cur  = (state == IDLE) ? iSize[1:0] : size_q;
  assign accept    = iSVAL && ((state == SHIFT) || size_ok);
  assign word_done = accept && (beat_cnt == BEAT_LAST);
  assign last_word = word_done && (word_idx == last_idx);
  assign shreg_nxt = DATA_W'({shreg, iSDAT});

  always_comb begin
    case (size_cur)
      2'd0:    last_idx = 5'd3;
      2'd1:    last_idx = 5'd7;
      2'd2:    last_idx = 5'd15;
      default: last_idx = 5'd31;
    endcase
  end

`ifdef DCT_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // reloaded on every accepted beat; expires on the TIMEOUT_CYC-th idle cycle
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= TW'(TIMEOUT_CYC - 1);
    end else if ((state == SHIFT) && !iSVAL && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign abort = (state == SHIFT) && !iSVAL && (tmo_cnt == '0);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    size_err_nxt = abort;
    case (state)
      IDLE: begin
        if (iSVAL) begin
          if (!size_ok)        size_err_nxt = 1'b1;
          else if (!last_word) state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (last_word || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      beat_cnt  <= '0;
      word_idx  <= '0;
      size_q    <= '0;
      size_err  <= 1'b0;
      push_vld  <= 1'b0;
      push_sof  <= 1'b0;
      push_eof  <= 1'b0;
      push_data <= '0;
    end else begin
      state    <= state_nxt;
      size_err <= size_err_nxt;
      push_vld <= word_done;
      if (word_done) begin
        push_data <= shreg_nxt;
        push_sof  <= (word_idx == 5'd0);
        push_eof  <= last_word;
      end
      if ((state == IDLE) && accept) size_q <= iSize[1:0];
      if (accept) begin
        shreg    <= shreg_nxt;
        beat_cnt <= word_done ? '0 : beat_cnt + 1'b1;
        if (word_done) word_idx <= last_word ? 5'd0 : word_idx + 5'd1;
      end
      if (abort) begin
        beat_cnt <= '0;
        word_idx <= '0;
      end
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [DATA_W+1:0] head;
  logic              empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && iReady;
  // a push into a full FIFO still lands when the head leaves in the same cycle
  assign wr_en = push_vld && (!full || pop);

  always_ff @(posedge iClk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_sof, push_eof, push_data};
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && full && !pop) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign oValid    = !empty;
  assign oData     = empty ? '0 : head[DATA_W-1:0];
  assign oSof      = !empty && head[DATA_W+1];
  assign oEof      = !empty && head[DATA_W];
  assign oOverflow = overflow;
  assign oSizeErr  = size_err;
  assign oBusy     = (state == SHIFT);

endmodule
